// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter.
//   mem_owner_t : tag carried through the read-return pipeline
//   mem_req_t   : one requester's request bundle, so the three ports mux uniformly
package cpu_types;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INSTR,
        OWN_DATA,
        OWN_DEBUG
    } mem_owner_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_req_t;

    localparam logic [3:0] BE_FULL = 4'b1111;

    // Instruction fetch is read-only: full-word enables, no write data.
    function automatic mem_req_t instr_req(input logic req, input logic [31:0] addr);
        mem_req_t r;
        r.req   = req;
        r.we    = 1'b0;
        r.addr  = addr;
        r.be    = BE_FULL;
        r.wdata = '0;
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_owner_pipe.sv
// mem_owner_pipe: DEPTH-stage shift register of owner tags, matching the RAM
// read latency so each returning word is attributed to its requester.
//   clk, rst_n : clock, synchronous active-low reset (clears all tags)
//   tag_i      : owner of the read issued this cycle (OWN_NONE otherwise)
//   tag_o      : owner of the read whose data is on mem_rdata this cycle
module mem_owner_pipe
    import cpu_types::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  mem_owner_t tag_i,
    output mem_owner_t tag_o
);

    mem_owner_t pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) pipe_q[k] <= OWN_NONE;
        end else begin
            pipe_q[0] <= tag_i;
            for (int k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between CPU
// instruction fetch (i_*), CPU data (d_*) and a debug/loader port (x_*).
// One access per cycle, granted combinationally; reads are tracked by an
// owner-tag pipeline so the matching *_rvalid fires MEM_LATENCY cycles later.
//   clk, rst_n            : clock, synchronous active-low reset
//   i_req/i_addr          : instruction read request; i_gnt, i_rvalid back
//   d_req/we/addr/be/wdata: data request; d_gnt, d_rvalid back
//   x_req/we/addr/be/wdata: debug request; x_gnt, x_rvalid back
//   rdata                 : shared read data (mem_rdata passthrough)
//   mem_*                 : RAM macro interface (word address)
module mem_port_arbiter
    import cpu_types::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [31:0]           i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [3:0]            d_be,
    input  logic [31:0]           d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    input  logic                  x_req,
    input  logic                  x_we,
    input  logic [31:0]           x_addr,
    input  logic [3:0]            x_be,
    input  logic [31:0]           x_wdata,
    output logic                  x_gnt,
    output logic                  x_rvalid,
    output logic [31:0]           rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    mem_req_t   i_r, d_r, x_r, g_r;
    mem_owner_t sel, tag_in, tag_out;
    logic [CW-1:0] starve_q, starve_d;
    logic x_pri;

    assign i_r = instr_req(i_req, i_addr);
    assign d_r = '{req: d_req, we: d_we, addr: d_addr, be: d_be, wdata: d_wdata};
    assign x_r = '{req: x_req, we: x_we, addr: x_addr, be: x_be, wdata: x_wdata};

    // Debug jumps the queue for one grant once it has waited STARVE_LIMIT cycles.
    assign x_pri = (starve_q == LIMIT);

    always_comb begin
        sel = OWN_NONE;
        g_r = '0;
        if (rst_n) begin
            if (x_pri && x_r.req) begin
                sel = OWN_DEBUG; g_r = x_r;
            end else if (d_r.req) begin
                sel = OWN_DATA;  g_r = d_r;
            end else if (i_r.req) begin
                sel = OWN_INSTR; g_r = i_r;
            end else if (x_r.req) begin
                sel = OWN_DEBUG; g_r = x_r;
            end
        end
    end

    assign i_gnt = (sel == OWN_INSTR);
    assign d_gnt = (sel == OWN_DATA);
    assign x_gnt = (sel == OWN_DEBUG);

    assign mem_en    = (sel != OWN_NONE);
    assign mem_we    = mem_en & g_r.we;
    assign mem_addr  = g_r.addr[ADDR_WIDTH+1:2];
    assign mem_be    = g_r.be;
    assign mem_wdata = g_r.wdata;

    // Byte offset and bits above the RAM range are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{g_r.addr[31:ADDR_WIDTH+2], g_r.addr[1:0]};

    always_comb begin
        starve_d = starve_q;
        if (!x_req || x_gnt)    starve_d = '0;
        else if (starve_q < LIMIT) starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) starve_q <= '0;
        else        starve_q <= starve_d;
    end

    assign tag_in = (mem_en && !g_r.we) ? sel : OWN_NONE;

    mem_owner_pipe #(.DEPTH(MEM_LATENCY)) u_owner_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // Gated by rst_n so a tag already at the output cannot fire during reset.
    assign i_rvalid = rst_n && (tag_out == OWN_INSTR);
    assign d_rvalid = rst_n && (tag_out == OWN_DATA);
    assign x_rvalid = rst_n && (tag_out == OWN_DEBUG);

    assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        i_req, d_req, d_we, x_req, x_we;
    logic [31:0] i_addr, d_addr, d_wdata, x_addr, x_wdata;
    logic [3:0]  d_be, x_be;

    // Instance 0: latency 1, instance 1: latency 3, instance 2: latency 2.
    logic [2:0]  i_gnt, d_gnt, x_gnt, i_rvalid, d_rvalid, x_rvalid, mem_en, mem_we;
    logic [9:0]  mem_addr [3];
    logic [3:0]  mem_be [3];
    logic [31:0] mem_wdata [3], mem_rdata [3], rdata [3];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] pat(input int a);
        return (a == 'h41) ? 32'hDEADBEEF : (32'hC0DE0000 | a);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 2;

        mem_port_arbiter #(.ADDR_WIDTH(10), .MEM_LATENCY(LAT), .STARVE_LIMIT(8)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt[g]), .i_rvalid(i_rvalid[g]),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
            .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]),
            .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_be(x_be), .x_wdata(x_wdata),
            .x_gnt(x_gnt[g]), .x_rvalid(x_rvalid[g]),
            .rdata(rdata[g]), .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_be(mem_be[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );

        // RAM model: byte-enabled write, LAT-cycle registered read.
        logic [31:0] mem [1024];
        logic [31:0] rq [4];
        initial for (int a = 0; a < 1024; a++) mem[a] = pat(a);
        always @(posedge clk) begin
            if (mem_en[g] && mem_we[g])
                for (int b = 0; b < 4; b++)
                    if (mem_be[g][b]) mem[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            rq[0] <= mem[mem_addr[g]];
            for (int k = 1; k < 4; k++) rq[k] <= rq[k-1];
        end
        assign mem_rdata[g] = rq[LAT-1];
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        i_req = 0; d_req = 0; x_req = 0; d_we = 0; x_we = 0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst_n = 0; i_req = 1; d_req = 1; x_req = 1; d_we = 1; x_we = 1;
        i_addr = 32'h4; d_addr = 32'h8; x_addr = 32'hC; d_be = 4'hF; x_be = 4'hF;
        d_wdata = 32'h0; x_wdata = 32'h0;
        step(); step();
        for (int g = 0; g < 3; g++) begin
            n_tests++;
            if ({i_gnt[g], d_gnt[g], x_gnt[g], mem_en[g], mem_we[g],
                 i_rvalid[g], d_rvalid[g], x_rvalid[g]} !== 8'b0) begin
                n_fail++;
                $display("FAIL reset[%0d]: gnt=%b%b%b en=%b we=%b rv=%b%b%b, want all 0", g,
                         i_gnt[g], d_gnt[g], x_gnt[g], mem_en[g], mem_we[g],
                         i_rvalid[g], d_rvalid[g], x_rvalid[g]);
            end
        end
        idle(0);
        rst_n = 1;
        step();
    endtask

    task automatic test_instr();
        i_req = 1; i_addr = 32'h104;
        #1;
        n_tests++;
        if (i_gnt[0] !== 1'b1 || d_gnt[0] !== 1'b0 || x_gnt[0] !== 1'b0 || mem_addr[0] !== 10'h041
            || mem_we[0] !== 1'b0 || mem_be[0] !== 4'hF || mem_en[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL instr_issue: gnt=%b en=%b we=%b addr=%h be=%h, want gnt=1 en=1 we=0 addr=041 be=f",
                     i_gnt[0], mem_en[0], mem_we[0], mem_addr[0], mem_be[0]);
        end
        step(); i_req = 0;
        n_tests++;
        if (i_rvalid[0] !== 1'b1 || d_rvalid[0] !== 1'b0 || x_rvalid[0] !== 1'b0
            || rdata[0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL instr_return: rv=%b%b%b rdata=%h, want 100 deadbeef",
                     i_rvalid[0], d_rvalid[0], x_rvalid[0], rdata[0]);
        end
        idle(4);
    endtask

    task automatic test_contention();
        i_req = 1; i_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h200; d_be = 4'hF;
        #1;
        n_tests++;
        if (d_gnt[0] !== 1'b1 || i_gnt[0] !== 1'b0 || mem_addr[0] !== 10'h080) begin
            n_fail++;
            $display("FAIL contention_first: d_gnt=%b i_gnt=%b addr=%h, want 1 0 080",
                     d_gnt[0], i_gnt[0], mem_addr[0]);
        end
        step(); d_req = 0; #1;
        n_tests++;
        if (i_gnt[0] !== 1'b1 || d_rvalid[0] !== 1'b1 || i_rvalid[0] !== 1'b0
            || rdata[0] !== 32'hC0DE0080) begin
            n_fail++;
            $display("FAIL contention_second: i_gnt=%b d_rv=%b i_rv=%b rdata=%h, want 1 1 0 c0de0080",
                     i_gnt[0], d_rvalid[0], i_rvalid[0], rdata[0]);
        end
        step(); i_req = 0;
        n_tests++;
        if (i_rvalid[0] !== 1'b1 || d_rvalid[0] !== 1'b0 || rdata[0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL contention_order: i_rv=%b d_rv=%b rdata=%h, want 1 0 deadbeef",
                     i_rvalid[0], d_rvalid[0], rdata[0]);
        end
        idle(4);
    endtask

    task automatic test_write();
        d_req = 1; d_we = 1; d_be = 4'b0011; d_wdata = 32'h0000ABCD; d_addr = 32'h8;
        #1;
        n_tests++;
        if (d_gnt[0] !== 1'b1 || mem_we[0] !== 1'b1 || mem_addr[0] !== 10'h2
            || mem_be[0] !== 4'b0011 || mem_wdata[0] !== 32'h0000ABCD) begin
            n_fail++;
            $display("FAIL write_issue: gnt=%b we=%b addr=%h be=%b wdata=%h, want 1 1 002 0011 0000abcd",
                     d_gnt[0], mem_we[0], mem_addr[0], mem_be[0], mem_wdata[0]);
        end
        step(); d_req = 0; d_we = 0;
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (d_rvalid !== 3'b000) begin
                n_fail++;
                $display("FAIL write_no_rvalid cycle %0d: d_rvalid=%b, want 000", c, d_rvalid);
            end
            step();
        end
        // Read back: only the enabled low half should have changed.
        d_req = 1; d_be = 4'hF;
        step(); d_req = 0;
        n_tests++;
        if (d_rvalid[0] !== 1'b1 || rdata[0] !== 32'hC0DEABCD) begin
            n_fail++;
            $display("FAIL write_readback: d_rv=%b rdata=%h, want 1 c0deabcd", d_rvalid[0], rdata[0]);
        end
        idle(4);
    endtask

    task automatic test_starvation();
        x_req = 1; x_we = 0; x_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h20;
        for (int c = 1; c <= 10; c++) begin
            #1;
            n_tests++;
            if (x_gnt[0] !== (c == 9) || d_gnt[0] !== (c != 9)) begin
                n_fail++;
                $display("FAIL starvation cycle %0d: x_gnt=%b d_gnt=%b, want %b %b",
                         c, x_gnt[0], d_gnt[0], c == 9, c != 9);
            end
            step();
        end
        idle(4);
    endtask

    task automatic test_latency();
        d_req = 1; d_we = 0; d_addr = 32'h20;
        #1;
        n_tests++;
        if (d_gnt[1] !== 1'b1) begin
            n_fail++; $display("FAIL latency_d_gnt: got %b, want 1", d_gnt[1]);
        end
        step(); d_req = 0; i_req = 1; i_addr = 32'h104;
        step(); i_req = 0; x_req = 1; x_addr = 32'h30;
        step(); x_req = 0;
        n_tests++;
        if ({d_rvalid[1], i_rvalid[1], x_rvalid[1]} !== 3'b100 || rdata[1] !== 32'hC0DE0008) begin
            n_fail++;
            $display("FAIL latency_+3: d/i/x rv=%b%b%b rdata=%h, want 100 c0de0008",
                     d_rvalid[1], i_rvalid[1], x_rvalid[1], rdata[1]);
        end
        step();
        n_tests++;
        if ({d_rvalid[1], i_rvalid[1], x_rvalid[1]} !== 3'b010 || rdata[1] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL latency_+4: d/i/x rv=%b%b%b rdata=%h, want 010 deadbeef",
                     d_rvalid[1], i_rvalid[1], x_rvalid[1], rdata[1]);
        end
        step();
        n_tests++;
        if ({d_rvalid[1], i_rvalid[1], x_rvalid[1]} !== 3'b001 || rdata[1] !== 32'hC0DE000C) begin
            n_fail++;
            $display("FAIL latency_+5: d/i/x rv=%b%b%b rdata=%h, want 001 c0de000c",
                     d_rvalid[1], i_rvalid[1], x_rvalid[1], rdata[1]);
        end
        step();
        n_tests++;
        if ({d_rvalid[1], i_rvalid[1], x_rvalid[1]} !== 3'b000) begin
            n_fail++;
            $display("FAIL latency_+6: d/i/x rv=%b%b%b, want 000",
                     d_rvalid[1], i_rvalid[1], x_rvalid[1]);
        end
        idle(4);
    endtask

    task automatic test_reset_midflight();
        d_req = 1; d_we = 0; d_addr = 32'h40;
        #1;
        n_tests++;
        if (d_gnt[2] !== 1'b1) begin
            n_fail++; $display("FAIL midflight_gnt: got %b, want 1", d_gnt[2]);
        end
        step(); d_req = 0; rst_n = 0; #1;
        n_tests++;
        if ({d_gnt[2], mem_en[2], mem_we[2], d_rvalid[2], i_rvalid[2], x_rvalid[2]} !== 6'b0) begin
            n_fail++; $display("FAIL midflight_in_reset: outputs=%b, want 000000",
                {d_gnt[2], mem_en[2], mem_we[2], d_rvalid[2], i_rvalid[2], x_rvalid[2]});
        end
        step();
        rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if ({d_rvalid[2], i_rvalid[2], x_rvalid[2], mem_en[2], d_gnt[2]} !== 5'b0) begin
                n_fail++; $display("FAIL midflight_after_reset cycle %0d: rv/en/gnt=%b, want 00000", c,
                    {d_rvalid[2], i_rvalid[2], x_rvalid[2], mem_en[2], d_gnt[2]});
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_instr();
        test_contention();
        test_write();
        test_starvation();
        test_latency();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous RAM between three requesters: CPU instruction fetch (read-only), CPU data access (read/write with byte enables) and a debug/loader port. It sits between the core's instruction/data memory ports and the physical RAM macro. Per cycle it issues at most one RAM access, tracks in-flight reads with an owner-tag pipeline, and routes read-valid back to the originator. The core stalls on a missing grant.

Parameters:
ADDR_WIDTH, 10, RAM word-address width; the RAM holds 2^ADDR_WIDTH 32-bit words
MEM_LATENCY, 1, RAM read latency in cycles; legal range 1..4
STARVE_LIMIT, 8, consecutive denied-request cycles after which the debug port is promoted to top priority

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_req  in  1  instruction read request
i_addr  in  32  instruction byte address
i_gnt  out  1  instruction request accepted this cycle
i_rvalid  out  1  instruction read data valid
d_req  in  1  data request
d_we  in  1  data write enable
d_addr  in  32  data byte address
d_be  in  4  data byte enables
d_wdata  in  32  data write data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  data read data valid
x_req  in  1  debug request
x_we  in  1  debug write enable
x_addr  in  32  debug byte address
x_be  in  4  debug byte enables
x_wdata  in  32  debug write data
x_gnt  out  1  debug request accepted this cycle
x_rvalid  out  1  debug read data valid
rdata  out  32  shared read data; equals mem_rdata
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_WIDTH  RAM word address
mem_be  out  4  RAM byte enables
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, MEM_LATENCY cycles after a read strobe

Behaviour:
- Reset (rst_n=0 at a clk edge): clear owner pipeline and starvation counter. During reset, all gnt, all rvalid, mem_en and mem_we are 0. No rvalid ever fires for a read issued before reset.
- Handshake: a requester holds req and its fields stable until it samples gnt=1. gnt is combinational in the same cycle, and the access is issued to RAM in that cycle. req may drop only after gnt.
- Priority: normally data > instruction > debug. When the starvation counter reaches STARVE_LIMIT, debug is top priority for exactly one grant.
- Exactly one gnt is high per cycle, and only if the corresponding req is high. When no req is high, mem_en=0.
- Starvation counter: increments on each cycle with x_req=1 and x_gnt=0, saturating at STARVE_LIMIT. Clears on x_gnt or when x_req=0.
- RAM drive: mem_en=1 on any grant. mem_we is the granted requester's we; forced 0 for instruction. mem_addr = granted addr[ADDR_WIDTH+1:2]; upper bits and addr[1:0] are ignored. mem_be/mem_wdata come from the granted requester; instruction drives be=4'b1111 and wdata=0.
- Owner pipeline: MEM_LATENCY-deep shift register of owner tags. Each cycle it shifts in the granted owner for reads, else NONE.
  - The tag at the output raises exactly one of i/d/x_rvalid for one cycle, MEM_LATENCY cycles after the grant.
  - Writes produce no rvalid.
- Back-to-back: a new grant is legal every cycle, including while earlier reads are in flight; return order equals issue order.
- Simultaneous events: all three requests high gives d_gnt; instruction waits. A write grant in the same cycle a read returns is legal.
- rdata is driven regardless of rvalid; consumers qualify it with rvalid.

Decomposition:
- cpu_types package gets mem_owner_t enum {OWN_NONE, OWN_INSTR, OWN_DATA, OWN_DEBUG}.
- cpu_types also gets a mem_req_t struct {req, we, addr, be, wdata} so the three ports are muxed uniformly.
- One natural sub-module: mem_owner_pipe (parameterised depth, mem_owner_t in/out, synchronous reset).
- Priority select and starvation counter stay in mem_port_arbiter.

Test Plan:
- Instruction only: i_req=1, i_addr=0x104, mem_rdata model returns 0xDEADBEEF → i_gnt=1 same cycle, mem_addr=0x041, i_rvalid=1 with rdata=0xDEADBEEF 1 cycle later; d_rvalid=x_rvalid=0.
- Contention: i_req and d_req both high with d_we=0, d_addr=0x200 → d_gnt=1, i_gnt=0. Next cycle i_gnt=1. Rvalids return d then i on consecutive cycles.
- Write: d_req=1, d_we=1, d_be=4'b0011, d_wdata=0x0000ABCD, d_addr=0x8 → mem_we=1, mem_addr=2, mem_be=4'b0011. No d_rvalid follows.
- Starvation: x_req and d_req held high continuously with STARVE_LIMIT=8 → x_gnt=0 for 8 cycles, x_gnt=1 on the 9th, counter clears, d_gnt resumes.
- Latency: MEM_LATENCY=3, reads granted d,i,x on three successive cycles → d_rvalid, i_rvalid, x_rvalid on cycles +3, +4, +5, one-hot.
- Reset mid-flight: MEM_LATENCY=2, grant d read, assert rst_n=0 next cycle → no d_rvalid appears. All outputs are 0 while in reset and afterwards until a new req is granted.
